clk_en_meter: RTL
=================

Name: clk_en_meter

Overview:
- Measures the average rate of a clock-enable pulse train and recovers the fractional `freq` value that produced it: `freq` = pulses per INPUT_FREQ clk cycles.
- Counterpart to the fractional clock-enable generator. Used to check pixel-enable and other strobe rates in the display pipeline, and as a self-check monitor.
- Counts `en_in`-high cycles over a fixed window of W = INPUT_FREQ << WINDOW_SHIFT clk cycles. Result is rounded and saturated, then presented with a 1-cycle `valid`.

Parameters:
- INPUT_FREQ, 128, clk cycles per unit of `freq`; must be ≥1.
- WINDOW_SHIFT, 4, window = INPUT_FREQ·2^WINDOW_SHIFT cycles; must be ≥1.
- FREQ_WIDTH, 8, width of the `freq` result.
- Derived, local: W = INPUT_FREQ << WINDOW_SHIFT; CNT_WIDTH = $clog2(W+1). Both the window counter and the pulse counter are CNT_WIDTH bits.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, asynchronous, active-high.
- en_in, input, 1, enable pulse train under measurement, synchronous to clk.
- start, input, 1, request one measurement; sampled in IDLE only.
- busy, output, 1, high while a window is in progress.
- valid, output, 1, 1-cycle pulse: `freq`/`overflow` updated.
- freq, output, FREQ_WIDTH, last measured rate.
- overflow, output, 1, last result saturated.

Behaviour:
- Reset: state=IDLE, busy=0, valid=0, freq=0, overflow=0; both counters cleared. Asserting rst mid-window aborts it; nothing is reported.
- States: IDLE, MEASURE. busy is registered and equals (state==MEASURE).
- IDLE → MEASURE: on the edge where start=1 (edge E0). On that edge the window counter loads W-1 and the pulse count clears.
- MEASURE sampling: en_in is sampled on edges E1..EW (exactly W samples).
  - Each edge: pulse count += en_in; window counter -= 1.
- Final edge EW (window counter==0): final = count + en_in, formed combinationally so the last sample is included. On EW:
  - rounded = (final + 2^(WINDOW_SHIFT-1)) >> WINDOW_SHIFT.
  - If rounded > 2^FREQ_WIDTH−1: freq = all-ones, overflow=1. Else freq = rounded, overflow=0.
  - valid=1 for exactly the cycle after EW.
  - state → IDLE.
- Latency: valid is high W cycles after the start-accepting edge. Minimum start-to-start period is W+1 cycles.
- Arithmetic: all intermediate sums use CNT_WIDTH+1 bits; no wrap. Max count is W, which must not overflow.
- Result hold: freq and overflow hold until the next valid.
- start while busy: ignored, no queuing. start asserted in the same cycle as valid is accepted, because state is IDLE then.
- en_in held high for the whole window gives freq = INPUT_FREQ exactly.

Optional Feature:
- Macro: CLK_EN_METER_CONTINUOUS_EN.
- Defined:
  - Enters MEASURE automatically on the first edge after rst deasserts; start is ignored.
  - On EW the window counter reloads W-1 and the count reloads 0, and state stays MEASURE. Windows are back-to-back with no gap; every clk cycle is sampled.
  - valid pulses every W cycles; busy stays 1 after the first post-reset edge.
- Undefined: single-shot behaviour as above.

Test Plan:
1. Defaults (W=2048). en_in=1 constantly, pulse start → valid exactly 2048 cycles after the start edge; freq=128, overflow=0, busy low on the valid cycle.
2. en_in=0 constantly → freq=0, overflow=0. Then pulse start 5 times during busy → still exactly one valid.
3. en_in driven by a fractional enable generator with freq=3, INPUT_FREQ=128 → 48 pulses per window, freq=3. Repeat with freq=77 → freq=77.
4. Rounding: en_in high for exactly 24 cycles of the window → freq=2; 23 cycles → freq=1; 8 cycles → freq=1; 7 → freq=0.
5. FREQ_WIDTH=7, en_in=1 constantly → freq=127, overflow=1. Next window with en_in=0 → freq=0, overflow=0.
6. rst asserted 1000 cycles into a window → busy=0, valid never pulses, freq keeps 0. With CLK_EN_METER_CONTINUOUS_EN and en_in=1: valid at cycles W, 2W, 3W after reset release, each with freq=128.

Source files
------------

// File: rtl/clk_en_meter.sv
`default_nettype none
// ============================================================================
// Module   : clk_en_meter
// Purpose  : Measures the average rate of a clock-enable pulse train and
//            recovers the fractional freq value that produced it
//            (freq = pulses per INPUT_FREQ clk cycles). A measurement counts
//            en_in-high cycles over a window of INPUT_FREQ << WINDOW_SHIFT
//            cycles, rounds to nearest, saturates to FREQ_WIDTH bits and
//            reports the result with a one-cycle valid pulse.
// Option   : CLK_EN_METER_CONTINUOUS_EN - free-running back-to-back windows
//            starting on the first edge after reset; start is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module clk_en_meter #(
  parameter int INPUT_FREQ   = 128,
  parameter int WINDOW_SHIFT = 4,
  parameter int FREQ_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  valid,
  output logic [FREQ_WIDTH-1:0] freq,
  output logic                  overflow
);

  // --------------------------------------------------------------------------
  // Derived sizes
  // --------------------------------------------------------------------------
  localparam int W          = INPUT_FREQ << WINDOW_SHIFT;
  localparam int CNT_WIDTH  = $clog2(W + 1);
  // One spare bit so count + last sample + rounding half never wraps.
  localparam int SUM_WIDTH  = CNT_WIDTH + 1;
  // Comparison width wide enough for both the rounded sum and the
  // all-ones saturation limit plus one guard bit.
  localparam int CMP_WIDTH  = (SUM_WIDTH > FREQ_WIDTH + 1) ? SUM_WIDTH : FREQ_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0] WIN_LOAD = CNT_WIDTH'(W - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [SUM_WIDTH-1:0] HALF_LSB = SUM_WIDTH'(1) << (WINDOW_SHIFT - 1);
  localparam logic [CMP_WIDTH-1:0] FREQ_MAX =
    {{(CMP_WIDTH - FREQ_WIDTH){1'b0}}, {FREQ_WIDTH{1'b1}}};

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  if (INPUT_FREQ < 1) begin : g_bad_input_freq
    $error("clk_en_meter: INPUT_FREQ must be >= 1");
  end
  if (WINDOW_SHIFT < 1) begin : g_bad_window_shift
    $error("clk_en_meter: WINDOW_SHIFT must be >= 1");
  end
  if (FREQ_WIDTH < 1) begin : g_bad_freq_width
    $error("clk_en_meter: FREQ_WIDTH must be >= 1");
  end

  // --------------------------------------------------------------------------
  // State and datapath signals
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   win_cnt;
  logic [CNT_WIDTH-1:0]   pulse_cnt;
  logic                   load_window;
  logic                   window_done;

  logic [SUM_WIDTH-1:0]   final_cnt;
  logic [SUM_WIDTH-1:0]   rounded_sum;
  logic [SUM_WIDTH-1:0]   rounded;
  logic [CMP_WIDTH-1:0]   rounded_ext;
  logic                   saturate;

`ifdef CLK_EN_METER_CONTINUOUS_EN
  // Free-running mode never looks at start.
  logic unused_start;
  assign unused_start = start;
`endif

  // --------------------------------------------------------------------------
  // Result arithmetic: the final sample is folded in combinationally so the
  // window really covers W samples, then round-to-nearest and saturate.
  // --------------------------------------------------------------------------
  assign final_cnt   = {1'b0, pulse_cnt} + {{CNT_WIDTH{1'b0}}, en_in};
  assign rounded_sum = final_cnt + HALF_LSB;
  assign rounded     = rounded_sum >> WINDOW_SHIFT;
  assign rounded_ext = CMP_WIDTH'(rounded);
  assign saturate    = (rounded_ext > FREQ_MAX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: window start on request (or immediately when
  // free-running), window end when the down-counter reaches zero.
  always_comb begin
    state_nxt   = state;
    load_window = 1'b0;
    window_done = 1'b0;
    case (state)
      IDLE: begin
`ifdef CLK_EN_METER_CONTINUOUS_EN
        state_nxt   = MEASURE;
        load_window = 1'b1;
`else
        if (start) begin
          state_nxt   = MEASURE;
          load_window = 1'b1;
        end
`endif
      end
      MEASURE: begin
        if (win_cnt == '0) begin
          window_done = 1'b1;
`ifdef CLK_EN_METER_CONTINUOUS_EN
          load_window = 1'b1;
`else
          state_nxt   = IDLE;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Window down-counter and pulse accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt   <= '0;
      pulse_cnt <= '0;
    end else if (load_window) begin
      win_cnt   <= WIN_LOAD;
      pulse_cnt <= '0;
    end else if ((state == MEASURE) && !window_done) begin
      win_cnt   <= win_cnt - CNT_ONE;
      pulse_cnt <= pulse_cnt + {{(CNT_WIDTH - 1){1'b0}}, en_in};
    end
  end

  // busy mirrors the registered state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_nxt == MEASURE);
    end
  end

  // Result capture on the last window edge; held until the next result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      freq     <= '0;
      overflow <= 1'b0;
    end else begin
      valid <= window_done;
      if (window_done) begin
        if (saturate) begin
          freq     <= '1;
          overflow <= 1'b1;
        end else begin
          freq     <= rounded_ext[FREQ_WIDTH-1:0];
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
